// File: rtl/sweep_sequencer_pkg.sv
// Shared types for the DDS frequency-sweep controller.
// FSM state encoding, default widths and the decoder opcodes for sweep control.
package sweep_sequencer_pkg;

  localparam int M_W_DEF     = 32;
  localparam int DWELL_W_DEF = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DWELL,
    S_FINISH
  } state_e;

  // Command-decoder opcodes that drive start/abort.
  localparam logic [3:0] OP_SWEEP = 4'h8;
  localparam logic [3:0] OP_ABORT = 4'h9;

endpackage

// File: rtl/sweep_sequencer_dwell_timer.sv
// Loadable down-counter with zero flag, used to hold each sweep point.
// Ports: clk, rst_n (sync, active low), load_i/load_val_i, dec_i, zero_o.
module sweep_sequencer_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency-sweep controller: steps DDS tuning word m from start to stop.
// Ports: cfg_start/stop/step/dwell, start/abort in; m, set, busy, done out.
// Option: SWEEP_REPEAT_EN restarts the sweep instead of finishing.
module sweep_sequencer
  import sweep_sequencer_pkg::*;
#(
  parameter int M_W     = M_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [M_W-1:0]     cfg_start,
  input  logic [M_W-1:0]     cfg_stop,
  input  logic [M_W-1:0]     cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               start,
  input  logic               abort,
  output logic [M_W-1:0]     m,
  output logic               set,
  output logic               busy,
  output logic               done
);

  state_e state_q, state_d;

  logic [M_W-1:0]     start_q, stop_q, step_q;
  logic [DWELL_W-1:0] rld_q;

  logic [M_W-1:0] m_d;
  logic           set_d, busy_d, done_d;

  logic lat_en, ld, dec, zero;
  logic more;

  logic [M_W:0]   nxt_w;
  logic [M_W-1:0] nxt;

  // Carry out or overshoot both clamp to stop, so the last point is stop.
  always_comb begin
    nxt_w = {1'b0, m} + {1'b0, step_q};
    if (nxt_w[M_W] || (nxt_w[M_W-1:0] > stop_q)) begin
      nxt = stop_q;
    end else begin
      nxt = nxt_w[M_W-1:0];
    end
  end

  assign more = (m != stop_q) && (step_q != '0) && (start_q <= stop_q);

  sweep_sequencer_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ld),
    .load_val_i (rld_q),
    .dec_i      (dec),
    .zero_o     (zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m       <= '0;
      set     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      rld_q   <= '0;
    end else begin
      state_q <= state_d;
      m       <= m_d;
      set     <= set_d;
      busy    <= busy_d;
      done    <= done_d;
      if (lat_en) begin
        start_q <= cfg_start;
        stop_q  <= cfg_stop;
        step_q  <= cfg_step;
        // Store D-1 with D = max(dwell,1).
        rld_q   <= (cfg_dwell == '0) ? '0
                                     : cfg_dwell - DWELL_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_EMIT;
      end
      S_EMIT: begin
        state_d = abort ? S_IDLE : S_DWELL;
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (zero && !more) begin
`ifdef SWEEP_REPEAT_EN
          state_d = S_DWELL;
`else
          state_d = S_FINISH;
`endif
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next point is issued on the edge that ends the dwell, so set
  // pulses are exactly D cycles apart with no separate STEP cycle.
  always_comb begin
    m_d    = m;
    set_d  = 1'b0;
    busy_d = busy;
    done_d = 1'b0;
    lat_en = 1'b0;
    ld     = 1'b0;
    dec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        lat_en = start && !abort;
      end
      S_EMIT: begin
        if (abort) begin
          busy_d = 1'b0;
        end else begin
          m_d    = start_q;
          set_d  = 1'b1;
          busy_d = 1'b1;
          ld     = 1'b1;
        end
      end
      S_DWELL: begin
        if (abort) begin
          busy_d = 1'b0;
        end else if (!zero) begin
          dec = 1'b1;
        end else if (more) begin
          m_d   = nxt;
          set_d = 1'b1;
          ld    = 1'b1;
        end else begin
`ifdef SWEEP_REPEAT_EN
          m_d   = start_q;
          set_d = 1'b1;
          ld    = 1'b1;
`else
          done_d = 1'b1;
          busy_d = 1'b0;
`endif
        end
      end
      S_FINISH: begin
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer with a point-list reference model.
// Build with SWEEP_REPEAT_EN to exercise the repeating sweep.
module tb_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_start = '0;
  logic [31:0] cfg_stop = '0;
  logic [31:0] cfg_step = '0;
  logic [23:0] cfg_dwell = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] m;
  logic        set, busy, done;

  sweep_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .start     (start),
    .abort     (abort),
    .m         (m),
    .set       (set),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [31:0] m;
    int          cyc;
  } ev_t;

  ev_t expq[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every set/done the DUT shows must match the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (set || done)) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: set=%0b done=%0b m=%0h cyc=%0d",
                   set, done, m, cyc);
        end else begin
          ev_t e;
          e = expq.pop_front();
          chk("ev_kind_done", 64'(done), 64'(e.is_done));
          chk("ev_kind_set", 64'(set), 64'(!e.is_done));
          chk("ev_cycle", 64'(cyc), 64'(e.cyc));
          if (!e.is_done) begin
            chk("set_m", 64'(m), 64'(e.m));
            chk("set_busy", 64'(busy), 64'd1);
          end else begin
            chk("done_busy", 64'(busy), 64'd0);
          end
        end
      end
    end
  end

  task automatic randomize_cfg();
    cfg_start = $urandom;
    cfg_stop  = $urandom;
    cfg_step  = $urandom;
    cfg_dwell = 24'($urandom_range(0, 7));
  endtask

  // abort_off: edge offset from the start edge at which abort/reset hits
  // (0 = run to completion). poke_start: retrigger start mid-sweep.
  task automatic run(input logic [31:0] s, input logic [31:0] e,
                     input logic [31:0] st, input logic [23:0] dw,
                     input int abort_off, input bit use_rst,
                     input bit poke_start);
    longint      pts[$];
    longint      p;
    int          d, t, n, lim, budget;
    logic [31:0] last_m;
    d = (dw == 0) ? 1 : int'(dw);
    p = longint'(s);
    pts.push_back(p);
    if (st != 0 && s <= e) begin
      while (p != longint'(e)) begin
        p = p + longint'(st);
        if (p > longint'(e)) p = longint'(e);
        pts.push_back(p);
      end
    end
    n = pts.size();
`ifdef SWEEP_REPEAT_EN
    if (abort_off == 0) abort_off = 2 * n * d + 3;
`endif
    @(negedge clk);
    cfg_start = s;
    cfg_stop  = e;
    cfg_step  = st;
    cfg_dwell = dw;
    start     = 1'b1;
    t = cyc + 1;
    lim = (abort_off == 0) ? 32'h7fff_ffff : t + abort_off;
    last_m = m;
    for (int k = 0; ; k++) begin
      int c;
      c = t + 1 + k * d;
      if (c >= lim) break;
`ifndef SWEEP_REPEAT_EN
      if (k >= n) begin
        expq.push_back('{1'b1, 32'h0, c});
        break;
      end
`endif
      last_m = 32'(pts[k % n]);
      expq.push_back('{1'b0, last_m, c});
    end
    @(negedge clk);
    start = 1'b0;
    randomize_cfg();
    if (poke_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      randomize_cfg();
    end
    if (abort_off != 0) begin
      while (cyc < t + abort_off - 1) @(negedge clk);
      if (use_rst) rst_n = 1'b0;
      else abort = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_set", 64'(set), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_m", 64'(m), use_rst ? 64'd0 : 64'(last_m));
    end else begin
      budget = n * d + 20;
      while (expq.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      chk("drain_timeout", 64'(budget == 0), 64'd0);
      @(negedge clk);
      chk("end_busy", 64'(busy), 64'd0);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    expq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_m", 64'(m), 64'd0);
    chk("rst_set", 64'(set), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(32'd1000, 32'd1300, 32'd100, 24'd3, 0, 1'b0, 1'b0);
    run(32'd1000, 32'd1250, 32'd100, 24'd2, 0, 1'b0, 1'b0);
    run(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd1, 0, 1'b0, 1'b0);
    run(32'd1500, 32'd1800, 32'd0, 24'd0, 0, 1'b0, 1'b0);
    run(32'd2000, 32'd1000, 32'd50, 24'd0, 0, 1'b0, 1'b0);
    run(32'd777, 32'd777, 32'd5, 24'd2, 0, 1'b0, 1'b0);
    run(32'd1000, 32'd1300, 32'd100, 24'd3, 6, 1'b0, 1'b0);
    run(32'd1000, 32'd1300, 32'd100, 24'd3, 6, 1'b1, 1'b0);

    // abort and start together in IDLE: stays idle, no set
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_start_busy", 64'(busy), 64'd0);
    chk("abort_start_set", 64'(set), 64'd0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] s, e, st;
      logic [23:0] dw;
      int          npts, aoff;
      bit          poke;
      if (i % 5 == 4) begin
        s  = 32'hFFFF_F000 + $urandom_range(0, 255);
        e  = 32'hFFFF_FFFF - $urandom_range(0, 50);
        st = 32'($urandom_range(256, 1024));
      end else begin
        s  = 32'($urandom_range(0, 5000));
        e  = ($urandom_range(0, 5) == 0) ? s - 32'($urandom_range(1, 300))
                                         : s + 32'($urandom_range(0, 600));
        st = ($urandom_range(0, 6) == 0) ? 32'd0
                                         : 32'($urandom_range(20, 150));
      end
      dw   = 24'($urandom_range(0, 4));
      poke = ($urandom_range(0, 2) == 0);
      npts = (st == 0 || s >= e) ? 1 : int'((64'(e) - 64'(s) + 64'(st) - 1) / 64'(st)) + 1;
      aoff = 0;
      if ($urandom_range(0, 3) == 0 && npts * ((dw == 0) ? 1 : int'(dw)) >= 3) begin
        aoff = $urandom_range(3, npts * ((dw == 0) ? 1 : int'(dw)));
      end
      run(s, e, st, dw, aoff, ($urandom_range(0, 1) == 1), poke);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
